// File: rtl/seg_pkg.sv
// Shared types, glyph table and helpers for the seven-segment display scanner.
package seg_pkg;

    localparam logic [15:0] BCD_MAX = 16'd9999;

    // Segment patterns as {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_H     = 7'h76;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [3:0] {
        GLYPH_0 = 4'd0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4,
        GLYPH_5, GLYPH_6, GLYPH_7, GLYPH_8, GLYPH_9,
        GLYPH_E, GLYPH_H, GLYPH_DASH, GLYPH_BLANK
    } glyph_e;

    typedef enum logic { VIEW_CLOCK = 1'b0, VIEW_HOURS = 1'b1 } view_e;

    typedef enum logic [1:0] { CONV_IDLE, CONV_SHIFT, CONV_DONE } conv_state_e;

    // Anything above 9 cannot be shown as one digit and is flagged as 'E'.
    function automatic glyph_e digit_glyph(input logic [3:0] d);
        return (d <= 4'd9) ? glyph_e'(d) : GLYPH_E;
    endfunction

    function automatic logic [6:0] glyph_seg(input glyph_e g);
        case (g)
            GLYPH_0:    return SEG_0;
            GLYPH_1:    return SEG_1;
            GLYPH_2:    return SEG_2;
            GLYPH_3:    return SEG_3;
            GLYPH_4:    return SEG_4;
            GLYPH_5:    return SEG_5;
            GLYPH_6:    return SEG_6;
            GLYPH_7:    return SEG_7;
            GLYPH_8:    return SEG_8;
            GLYPH_9:    return SEG_9;
            GLYPH_E:    return SEG_E;
            GLYPH_H:    return SEG_H;
            GLYPH_DASH: return SEG_DASH;
            default:    return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit double-dabble: one load cycle, sixteen shift cycles, one done cycle.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    conv_state_e state, state_nxt;
    logic [15:0] bin_sh;
    logic [15:0] bcd_sh;
    logic [15:0] bcd_adj;
    logic [3:0]  shift_cnt;

    // Add-3 on every BCD digit that would overflow past 9 after the shift.
    always_comb begin
        bcd_adj = bcd_sh;
        for (int i = 0; i < 4; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE:  if (start) state_nxt = CONV_SHIFT;
            CONV_SHIFT: if (shift_cnt == 4'd15) state_nxt = CONV_DONE;
            CONV_DONE:  state_nxt = CONV_IDLE;
            default:    state_nxt = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CONV_IDLE;
            bin_sh    <= '0;
            bcd_sh    <= '0;
            shift_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                CONV_IDLE: if (start) begin
                    bin_sh    <= (bin > BCD_MAX) ? BCD_MAX : bin;
                    bcd_sh    <= '0;
                    shift_cnt <= '0;
                end
                CONV_SHIFT: begin
                    {bcd_sh, bin_sh} <= {bcd_adj, bin_sh} << 1;
                    shift_cnt        <= shift_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != CONV_IDLE);
    assign done = (state == CONV_DONE);
    assign bcd  = bcd_sh;

endmodule

// File: rtl/seg_display_scan.sv
// 8-digit multiplexed seven-segment scanner with per-frame input snapshot.
// Optional SEG_REMIND_BLINK_EN: blink the whole display while the reminder is active.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        power_on,
    input  logic        disp_sel,
    input  logic [5:0]  hour,
    input  logic [5:0]  minute,
    input  logic [5:0]  second,
    input  logic [3:0]  state_smoke_lvl,
    input  logic [15:0] work_hours,
    input  logic        remind,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        idx;
    logic              tick;
    logic              start;
    logic [5:0]        hour_q, minute_q, second_q;
    logic [3:0]        lvl_q;
    view_e             view_q;
    logic              remind_q;
    logic [15:0]       wh_bcd;
    logic [15:0]       conv_bcd;
    logic              conv_done;
    logic              unused_conv_busy;
    logic              remind_blank;
    glyph_e            glyph;
    logic              dp;
    logic [3:0]        hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units;

    assign tick  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign start = tick && (idx == 3'd7);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (tick) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Shadows change only at the frame boundary so a frame never mixes old and new values.
    always_ff @(posedge clk) begin
        if (reset) begin
            hour_q   <= '0;
            minute_q <= '0;
            second_q <= '0;
            lvl_q    <= '0;
            view_q   <= VIEW_CLOCK;
            remind_q <= 1'b0;
        end else if (start) begin
            hour_q   <= hour;
            minute_q <= minute;
            second_q <= second;
            lvl_q    <= state_smoke_lvl;
            view_q   <= view_e'(disp_sel);
            remind_q <= remind;
        end
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (work_hours),
        .busy  (unused_conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (reset)          wh_bcd <= '0;
        else if (conv_done) wh_bcd <= conv_bcd;
    end

`ifdef SEG_REMIND_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign remind_blank = remind_q && !blink_phase;
`else
    // Keeps BLINK_DIV referenced when the blink counter is compiled out.
    logic unused_blink_div;
    assign unused_blink_div = (BLINK_DIV > 0);
    assign remind_blank     = 1'b0;
`endif

    assign hour_tens  = 4'(hour_q / 6'd10);
    assign hour_units = 4'(hour_q % 6'd10);
    assign min_tens   = 4'(minute_q / 6'd10);
    assign min_units  = 4'(minute_q % 6'd10);
    assign sec_tens   = 4'(second_q / 6'd10);
    assign sec_units  = 4'(second_q % 6'd10);

    always_comb begin
        // NOTE: defaults first so every path assigns glyph/dp and no latch is inferred.
        glyph = GLYPH_BLANK;
        dp    = 1'b0;
        if (view_q == VIEW_CLOCK) begin
            case (idx)
                3'd7:    glyph = digit_glyph(lvl_q);
                3'd6:    glyph = GLYPH_DASH;
                3'd5:    glyph = digit_glyph(hour_tens);
                3'd4:    glyph = digit_glyph(hour_units);
                3'd3:    glyph = digit_glyph(min_tens);
                3'd2:    glyph = digit_glyph(min_units);
                3'd1:    glyph = digit_glyph(sec_tens);
                default: glyph = digit_glyph(sec_units);
            endcase
            dp = (idx == 3'd5) || (idx == 3'd3);
        end else begin
            case (idx)
                3'd7:    glyph = GLYPH_H;
                3'd3:    glyph = digit_glyph(wh_bcd[15:12]);
                3'd2:    glyph = digit_glyph(wh_bcd[11:8]);
                3'd1:    glyph = digit_glyph(wh_bcd[7:4]);
                3'd0:    glyph = digit_glyph(wh_bcd[3:0]);
                default: glyph = GLYPH_BLANK;
            endcase
        end
`ifndef SEG_REMIND_BLINK_EN
        if ((idx == 3'd7) && remind_q) dp = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || !power_on || remind_blank) begin
            an  <= '0;
            seg <= '0;
        end else begin
            an  <= 8'b1 << idx;
            seg <= {dp, glyph_seg(glyph)};
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan: constant vectors, corner sequences, random run vs model.
`timescale 1ns/1ps
module tb_seg_display_scan;

    localparam int SCAN_DIV  = 24;
    localparam int BLINK_DIV = 100;
    localparam int FRAME     = 8 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        power_on;
    logic        disp_sel;
    logic [5:0]  hour, minute, second;
    logic [3:0]  state_smoke_lvl;
    logic [15:0] work_hours;
    logic        remind;
    logic [7:0]  an, seg;

    seg_display_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk             (clk),
        .reset           (reset),
        .power_on        (power_on),
        .disp_sel        (disp_sel),
        .hour            (hour),
        .minute          (minute),
        .second          (second),
        .state_smoke_lvl (state_smoke_lvl),
        .work_hours      (work_hours),
        .remind          (remind),
        .an              (an),
        .seg             (seg)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference glyphs: 0-9 digits, 10 'E', 11 'H', 12 '-', else blank.
    function automatic logic [6:0] ref_glyph(input int code);
        case (code)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h79; 11: return 7'h76;
            12: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // Model: edge count since reset determines the digit, the frame boundary and the blink phase.
    int k, conv_due, conv_val, wh_val;
    int snap_h, snap_m, snap_s, snap_l, snap_sel, snap_rem;
    logic [7:0] exp_an, exp_seg;

    function automatic logic [7:0] model_seg(input int d);
        int code = 13;
        bit dpl  = 1'b0;
        if (snap_sel == 0) begin
            case (d)
                7: code = (snap_l < 10) ? snap_l : 10;
                6: code = 12;
                5: code = snap_h / 10;
                4: code = snap_h % 10;
                3: code = snap_m / 10;
                2: code = snap_m % 10;
                1: code = snap_s / 10;
                default: code = snap_s % 10;
            endcase
            dpl = (d == 5) || (d == 3);
        end else begin
            case (d)
                7: code = 11;
                3: code = wh_val / 1000;
                2: code = (wh_val / 100) % 10;
                1: code = (wh_val / 10) % 10;
                0: code = wh_val % 10;
                default: code = 13;
            endcase
        end
`ifndef SEG_REMIND_BLINK_EN
        if (d == 7 && snap_rem != 0) dpl = 1'b1;
`endif
        return {dpl, ref_glyph(code)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            k = 0; conv_due = -1; conv_val = 0; wh_val = 0;
            snap_h = 0; snap_m = 0; snap_s = 0; snap_l = 0; snap_sel = 0; snap_rem = 0;
            exp_an = 8'h00; exp_seg = 8'h00;
        end else begin
            int d;
            bit blank;
            k++;
            d     = ((k - 1) / SCAN_DIV) % 8;
            blank = !power_on;
`ifdef SEG_REMIND_BLINK_EN
            if (snap_rem != 0 && (((k - 1) / BLINK_DIV) % 2) == 0) blank = 1'b1;
`endif
            if (blank) begin
                exp_an = 8'h00; exp_seg = 8'h00;
            end else begin
                exp_an = 8'(1 << d); exp_seg = model_seg(d);
            end
            if (k % FRAME == 0) begin
                snap_h = int'(hour); snap_m = int'(minute); snap_s = int'(second);
                snap_l = int'(state_smoke_lvl); snap_sel = int'(disp_sel); snap_rem = int'(remind);
                conv_val = (int'(work_hours) > 9999) ? 9999 : int'(work_hours);
                conv_due = k + 17;
            end
            if (k == conv_due) wh_val = conv_val;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_an", an, exp_an);
            check("model_seg", seg, exp_seg);
        end
    end

    task automatic wait_an(input logic [7:0] target, input int budget, input string name);
        int n = 0;
        while (an !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, an, target);
    endtask

    typedef struct {
        logic [5:0]       hour, minute, second;
        logic [3:0]       lvl;
        logic             sel;
        logic [15:0]      wh;
        logic [7:0][7:0]  exp;   // exp[d] = expected seg on digit d
    } vec_t;

    vec_t vecs [7];

    task automatic apply(input vec_t v);
        hour = v.hour; minute = v.minute; second = v.second;
        state_smoke_lvl = v.lvl; disp_sel = v.sel; work_hours = v.wh;
        remind = 1'b0; power_on = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{6'd12, 6'd34, 6'd56, 4'd3,  1'b0, 16'd0,
                    {8'h4F, 8'h40, 8'h86, 8'h5B, 8'hCF, 8'h66, 8'h6D, 8'h7D}};
        vecs[1] = '{6'd0,  6'd0,  6'd0,  4'd0,  1'b1, 16'd1234,
                    {8'h76, 8'h00, 8'h00, 8'h00, 8'h06, 8'h5B, 8'h4F, 8'h66}};
        vecs[2] = '{6'd0,  6'd0,  6'd0,  4'd0,  1'b1, 16'd65535,
                    {8'h76, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h6F, 8'h6F, 8'h6F}};
        vecs[3] = '{6'd63, 6'd60, 6'd7,  4'd12, 1'b0, 16'd0,
                    {8'h79, 8'h40, 8'hFD, 8'h4F, 8'hFD, 8'h3F, 8'h3F, 8'h07}};
        vecs[4] = '{6'd0,  6'd0,  6'd0,  4'd0,  1'b1, 16'd0,
                    {8'h76, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h3F}};
        vecs[5] = '{6'd0,  6'd0,  6'd0,  4'd0,  1'b1, 16'd10000,
                    {8'h76, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h6F, 8'h6F, 8'h6F}};
        vecs[6] = '{6'd9,  6'd5,  6'd0,  4'd9,  1'b0, 16'd0,
                    {8'h6F, 8'h40, 8'hBF, 8'h6F, 8'hBF, 8'h6D, 8'h3F, 8'h3F}};

        reset = 1'b1; power_on = 1'b1; disp_sel = 1'b0; remind = 1'b0;
        hour = '0; minute = '0; second = '0; state_smoke_lvl = '0; work_hours = '0;
        repeat (3) @(negedge clk);
        check("reset_an", an, 8'h00);
        check("reset_seg", seg, 8'h00);
        check("reset_wh_bcd", dut.wh_bcd, 16'h0000);
        check("reset_conv_idle", dut.u_bcd.busy, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Constant vectors: hold two frames, then walk digits 0..7.
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i]);
            repeat (2 * FRAME + 8) @(negedge clk);
            for (int d = 0; d < 8; d++) begin
                wait_an(8'(1 << d), FRAME, $sformatf("vec%0d_an%0d", i, d));
                check($sformatf("vec%0d_seg%0d", i, d), seg, vecs[i].exp[d]);
            end
        end

        // Power drop mid-frame blanks on the next edge; shadows survive.
        apply(vecs[0]);
        repeat (2 * FRAME + 8) @(negedge clk);
        wait_an(8'h08, FRAME, "pwr_pre_an");
        power_on = 1'b0;
        @(negedge clk);
        check("pwr_off_an", an, 8'h00);
        check("pwr_off_seg", seg, 8'h00);
        repeat (30) @(negedge clk);
        power_on = 1'b1;
        @(negedge clk);
        check("pwr_on_an", an, exp_an);
        wait_an(8'h20, FRAME, "pwr_hour_an");
        check("pwr_hour_seg", seg, 8'h86);

        // Hour change at idx 3 only shows after the frame boundary.
        wait_an(8'h08, FRAME, "hchg_pre_an");
        hour = 6'd13;
        wait_an(8'h10, FRAME, "hchg_old_an");
        check("hchg_old_seg", seg, 8'h5B);
        wait_an(8'h01, FRAME, "hchg_wrap_an");
        wait_an(8'h10, FRAME, "hchg_new_an");
        check("hchg_new_seg", seg, 8'h4F);

        // Reminder behaviour.
        remind = 1'b1;
        repeat (2 * FRAME + 8) @(negedge clk);
        begin
            int blanks = 0;
            for (int c = 0; c < 4 * BLINK_DIV; c++) begin
                @(negedge clk);
                if (an == 8'h00) blanks++;
            end
`ifdef SEG_REMIND_BLINK_EN
            check("remind_blank_cycles", blanks, 2 * BLINK_DIV);
`else
            check("remind_blank_cycles", blanks, 0);
            wait_an(8'h80, FRAME, "remind_dp_an");
            check("remind_dp_seg", seg, 8'hCF);
`endif
        end
        remind = 1'b0;

        // Reset during a conversion aborts it; the next frame converts cleanly.
        disp_sel = 1'b1; work_hours = 16'd4321;
        repeat (2 * FRAME + 40) @(negedge clk);
        check("pre_rst_wh_bcd", dut.wh_bcd, 16'h4321);
        work_hours = 16'd1500;
        begin
            int n = 0;
            while (dut.u_bcd.busy !== 1'b1 && n < FRAME + SCAN_DIV) begin
                @(negedge clk);
                n++;
            end
            check("conv_started", dut.u_bcd.busy, 1'b1);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wh_bcd", dut.wh_bcd, 16'h0000);
        check("rst_conv_idle", dut.u_bcd.busy, 1'b0);
        reset = 1'b0;
        repeat (2 * FRAME + 40) @(negedge clk);
        check("reconv_wh_bcd", dut.wh_bcd, 16'h1500);
        wait_an(8'h04, FRAME, "reconv_an");
        check("reconv_seg", seg, 8'h6D);

        // Random inputs against the model.
        for (int r = 0; r < 14; r++) begin
            hour            = 6'($urandom_range(0, 63));
            minute          = 6'($urandom_range(0, 63));
            second          = 6'($urandom_range(0, 63));
            state_smoke_lvl = 4'($urandom_range(0, 15));
            work_hours      = 16'($urandom);
            disp_sel        = 1'($urandom_range(0, 1));
            remind          = 1'($urandom_range(0, 1));
            power_on        = ($urandom_range(0, 7) != 0);
            repeat (FRAME + $urandom_range(0, 2 * FRAME)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
